// File: rtl/partition_engine.sv
// In-place partition of vec[lo..hi] around the pivot vec[lo] for the quicksort datapath.
// Ascending/descending order, signed/unsigned compare, range error reporting.
module partition_engine #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    input  logic              desc,
    input  logic              signed_mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pivot_loc
);

    typedef enum logic [1:0] {IDLE, SCAN_R, SCAN_L} state_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] vec_reg [DEPTH];
    logic [ADDR_W-1:0] loc_reg, left_reg, right_reg, pivot_reg;
    logic              desc_reg, signed_reg, err_pend_reg;
    logic              done_reg, err_reg;
    logic [DATA_W-1:0] rd_data_reg;

    logic [ADDR_W-1:0] probe;
    logic [DATA_W-1:0] probe_val, loc_val;
    logic              range_bad, accept, wr_ok;
    logic              scanning, at_loc, take, finish, swap, step;

    function automatic logic before_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                      input logic dsc, input logic sgn);
        logic lt, gt;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        return dsc ? gt : lt;
    endfunction

    // SCAN_R walks right downward, SCAN_L walks left upward; both compare against the pivot at loc.
    assign probe     = (state_reg == SCAN_R) ? right_reg : left_reg;
    assign probe_val = vec_reg[probe];
    assign loc_val   = vec_reg[loc_reg];
    assign range_bad = (lo > hi) || ({1'b0, hi} >= LIMIT);
    assign accept    = (state_reg == IDLE) && start && !err_pend_reg;
    assign wr_ok     = (state_reg == IDLE) && wr_en;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && !range_bad) state_next = SCAN_R;
            SCAN_R:  if (finish) state_next = IDLE; else if (swap) state_next = SCAN_L;
            SCAN_L:  if (finish) state_next = IDLE; else if (swap) state_next = SCAN_R;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        scanning = (state_reg == SCAN_R) || (state_reg == SCAN_L);
        at_loc   = (probe == loc_reg);
        take     = (state_reg == SCAN_R) ? before_f(probe_val, loc_val, desc_reg, signed_reg)
                                         : before_f(loc_val, probe_val, desc_reg, signed_reg);
        finish   = scanning && at_loc;
        swap     = scanning && !at_loc && take;
        step     = scanning && !at_loc && !take;
    end

    // Storage is not reset; writes and swaps are exclusive because writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (wr_ok) vec_reg[wr_addr] <= wr_data;
        if (swap) begin
            vec_reg[loc_reg] <= probe_val;
            vec_reg[probe]   <= loc_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loc_reg      <= '0;
            left_reg     <= '0;
            right_reg    <= '0;
            pivot_reg    <= '0;
            desc_reg     <= 1'b0;
            signed_reg   <= 1'b0;
            err_pend_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_data_reg  <= vec_reg[rd_addr];
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_pend_reg <= 1'b0;
            // A bad range waits one cycle so its done lines up with a one-step partition.
            if (err_pend_reg) begin
                done_reg <= 1'b1;
                err_reg  <= 1'b1;
            end
            if (accept) begin
                desc_reg   <= desc;
                signed_reg <= signed_mode;
                if (range_bad) begin
                    err_pend_reg <= 1'b1;
                end else begin
                    loc_reg   <= lo;
                    left_reg  <= lo;
                    right_reg <= hi;
                end
            end
            if (finish) begin
                done_reg  <= 1'b1;
                pivot_reg <= loc_reg;
            end
            if (swap) loc_reg <= probe;
            if (step) begin
                if (state_reg == SCAN_R) right_reg <= right_reg - 1'b1;
                else                     left_reg  <= left_reg + 1'b1;
            end
        end
    end

    assign busy      = scanning;
    assign done      = done_reg;
    assign err       = err_reg;
    assign pivot_loc = pivot_reg;
    assign rd_data   = rd_data_reg;

endmodule

// File: doc/partition_engine.md
# partition_engine

Parametrised in-place partition engine for the hardware quicksort datapath. It holds a DEPTH-entry local array with random-access load and read ports. On `start` it partitions a sub-range [lo, hi] around the pivot at `vec[lo]`, then reports the pivot's final index to the sort sequencer. Over the previous fixed-width partition stage it adds:
- parametrised data width and depth;
- ascending or descending order;
- signed or unsigned compare;
- range error detection;
- clean start/busy/done handshaking.

## Interface
- `DATA_W`, 32, element width in bits
- `DEPTH`, 8, number of array entries (≥2)
- `ADDR_W`, $clog2(DEPTH), index width (derived, not overridden)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  write `wr_data` to `vec[wr_addr]`
- `wr_addr`  in  ADDR_W  load index
- `wr_data`  in  DATA_W  load data
- `rd_addr`  in  ADDR_W  read index
- `rd_data`  out  DATA_W  registered `vec[rd_addr]`
- `start`  in  1  begin partition of [lo, hi]
- `lo`, `hi`  in  ADDR_W  inclusive range bounds
- `desc`  in  1  1 = descending order, 0 = ascending
- `signed_mode`  in  1  1 = two's-complement compare
- `busy`  out  1  partition in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  qualifies `done`: range was invalid
- `pivot_loc`  out  ADDR_W  final pivot index, valid from `done` until next `done`

## Operation
- Order predicate `before(a,b)`:
  - `desc=0`: a<b; `desc=1`: a>b.
  - Signed or unsigned per `signed_mode`.
  - Equal values never swap.
- States: IDLE, SCAN_R, SCAN_L.
- IDLE with `start=1`:
  - Sample `lo`, `hi`, `desc`, `signed_mode` into registers.
  - If `lo>hi` or `hi≥DEPTH`: next edge `done=1`, `err=1`, array and `pivot_loc` unchanged, stay IDLE.
  - Otherwise: `loc<=lo`, `left<=lo`, `right<=hi`, `busy<=1`, go to SCAN_R.
- SCAN_R, one step per cycle, first match wins:
  - `right==loc`: finish.
  - `before(vec[right],vec[loc])`: swap the two entries, `loc<=right`, go to SCAN_L.
  - Else: `right<=right-1`.
- SCAN_L, symmetric, first match wins:
  - `left==loc`: finish.
  - `before(vec[loc],vec[left])`: swap, `loc<=left`, go to SCAN_R.
  - Else: `left<=left+1`.
- Finish:
  - `done<=1`, `err<=0`, `pivot_loc<=loc`, `busy<=0`, go to IDLE.
- Result: `vec[lo..pivot_loc-1]` never `before`-follows the pivot; `vec[pivot_loc+1..hi]` never precedes it. Entries outside [lo, hi] are untouched.
- `wr_en` is ignored while `busy`. `start` is ignored while `busy`.
- `rd_data` updates every cycle, including while busy, and shows the live array.
- IDLE write and `start` in the same cycle: the write lands, and the scan sees the new value.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `pivot_loc=0`, `rd_data=0`, state IDLE.
- Array contents are not reset.
- Reset mid-partition: returns to IDLE immediately with no `done`. The array holds a permutation of the pre-start contents.
- `rd_data` latency: 1 cycle.
- Partition latency:
  - `start` accepted at edge k.
  - Each scan cycle is one step.
  - `done` is high for exactly the one cycle after edge k+N, where N = scan cycles (≥1) and N ≤ 2·(hi−lo)+1.
- Error latency: `done` and `err` are high for one cycle after edge k+1.
- `busy` is high from edge k+1 through the cycle before `done`. `busy` and `done` are never high together.
- A new `start` may be issued in the cycle `done` is high; it is accepted then.

## Test plan
- Ascending, unsigned: load [5,3,8,1], `lo=0`, `hi=3` -> `done` at N=6, `pivot_loc=2`, array [1,3,5,8].
- Descending: same load, `desc=1` -> N=6, `pivot_loc=1`, array [8,5,3,1].
- Signed vs unsigned: load [0xFFFFFFFF, 2], range 0..1:
  - `signed_mode=1` -> N=2, `pivot_loc=0`, array unchanged.
  - `signed_mode=0` -> N=3, `pivot_loc=1`, array [2, 0xFFFFFFFF].
- Single element and error cases:
  - `lo=hi=4` -> N=1, `pivot_loc=4`.
  - `lo=5`, `hi=2` -> `done`=`err`=1 one cycle later, array unchanged.
- Interlocks: `wr_en` and a second `start` while busy -> both ignored, array equals the expected partition. Assert `rst` at scan cycle 3 -> no `done`, `busy=0` next cycle, array is a permutation of the input.
- Random regression: DATA_W=16, DEPTH=16, random ranges and modes vs a software model. Checks:
  - partition property holds;
  - entries outside [lo, hi] are unchanged;
  - N ≤ 2·(hi−lo)+1.
